// File: rtl/uart_stream_loader.sv
// uart_stream_loader: Avalon-MM master that drains UART data-register bytes into INSTR_WIDTH-bit
// words and writes them to consecutive instruction-memory addresses. Define UART_LOADER_CHECKSUM_EN to add checksum_out.
module uart_stream_loader #(
    parameter int ADDRESS_WIDTH = 11,
    parameter int INSTR_WIDTH   = 16,
    parameter bit MSB_FIRST     = 1'b1,
    parameter bit USE_IRQ       = 1'b1
) (
    input  logic                     clock_in,
    input  logic                     reset_in,
    input  logic                     start_in,
    input  logic [ADDRESS_WIDTH:0]   length_in,
    input  logic [31:0]              readdata_in,
    input  logic                     waitrequest_in,
    input  logic                     irq_in,
    output logic                     chipselect_out,
    output logic                     address_out,
    output logic                     read_n_out,
    output logic                     write_n_out,
    output logic                     memory_wr_out,
    output logic [ADDRESS_WIDTH-1:0] memory_address_out,
    output logic [INSTR_WIDTH-1:0]   memory_data_out,
    output logic                     busy_out,
`ifdef UART_LOADER_CHECKSUM_EN
    output logic [7:0]               checksum_out,
`endif
    output logic                     done_out
);

    localparam int BYTES = INSTR_WIDTH / 8;
    localparam logic [2:0] LAST_BYTE = 3'(BYTES - 1);
    localparam logic [ADDRESS_WIDTH:0] MAX_LEN = {1'b1, {ADDRESS_WIDTH{1'b0}}};
    localparam logic [ADDRESS_WIDTH:0] ONE_W = (ADDRESS_WIDTH + 1)'(1);

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_READ, S_EVAL, S_WRITE, S_DONE} state_t;

    state_t                   state_q;
    logic [ADDRESS_WIDTH:0]   len_q;
    logic [ADDRESS_WIDTH:0]   word_cnt_q;
    logic [ADDRESS_WIDTH:0]   word_cnt_next;
    logic [ADDRESS_WIDTH-1:0] addr_q;
    logic [2:0]               byte_cnt_q;
    logic [INSTR_WIDTH-1:0]   word_q;
    logic [INSTR_WIDTH-1:0]   next_word;
    logic                     rx_valid_q;
    logic [7:0]               rx_byte_q;
    logic                     unused_readdata;

    // Only RVALID and the data byte of the UART data register matter here.
    assign unused_readdata = &{1'b0, readdata_in[31:16], readdata_in[14:8]};

    assign address_out   = 1'b0;
    assign write_n_out   = 1'b1;
    assign word_cnt_next = word_cnt_q + ONE_W;

    always_comb begin
        // NOTE: next_word gets a value before any branch so no latch can be inferred.
        next_word = word_q;
        if (MSB_FIRST)
            next_word = (word_q << 8) | INSTR_WIDTH'(rx_byte_q);
        else
            next_word = word_q | (INSTR_WIDTH'(rx_byte_q) << {byte_cnt_q, 3'b000});
    end

    always_ff @(posedge clock_in) begin
        // NOTE: all state updates are non-blocking so every register samples pre-edge values.
        if (reset_in) begin
            state_q            <= S_IDLE;
            chipselect_out     <= 1'b0;
            read_n_out         <= 1'b1;
            memory_wr_out      <= 1'b0;
            memory_address_out <= '0;
            memory_data_out    <= '0;
            busy_out           <= 1'b0;
            done_out           <= 1'b0;
            len_q              <= '0;
            word_cnt_q         <= '0;
            addr_q             <= '0;
            byte_cnt_q         <= '0;
            word_q             <= '0;
            rx_valid_q         <= 1'b0;
            rx_byte_q          <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_in) begin
                        len_q      <= (length_in > MAX_LEN) ? MAX_LEN : length_in;
                        word_cnt_q <= '0;
                        addr_q     <= '0;
                        byte_cnt_q <= '0;
                        word_q     <= '0;
                        done_out   <= 1'b0;
                        busy_out   <= 1'b1;
                        state_q    <= (length_in == '0) ? S_DONE : S_WAIT;
                    end
                end
                S_WAIT: begin
                    // Strobes are registered here so they are already valid in READ.
                    if (!USE_IRQ || irq_in) begin
                        chipselect_out <= 1'b1;
                        read_n_out     <= 1'b0;
                        state_q        <= S_READ;
                    end
                end
                S_READ: begin
                    if (!waitrequest_in) begin
                        chipselect_out <= 1'b0;
                        read_n_out     <= 1'b1;
                        rx_valid_q     <= readdata_in[15];
                        rx_byte_q      <= readdata_in[7:0];
                        state_q        <= S_EVAL;
                    end
                end
                S_EVAL: begin
                    if (!rx_valid_q) begin
                        state_q <= S_WAIT;
                    end else if (byte_cnt_q == LAST_BYTE) begin
                        byte_cnt_q         <= '0;
                        word_q             <= '0;
                        memory_wr_out      <= 1'b1;
                        memory_address_out <= addr_q;
                        memory_data_out    <= next_word;
                        state_q            <= S_WRITE;
                    end else begin
                        byte_cnt_q <= byte_cnt_q + 3'd1;
                        word_q     <= next_word;
                        state_q    <= S_WAIT;
                    end
                end
                S_WRITE: begin
                    memory_wr_out <= 1'b0;
                    addr_q        <= addr_q + ADDRESS_WIDTH'(1);
                    word_cnt_q    <= word_cnt_next;
                    state_q       <= (word_cnt_next == len_q) ? S_DONE : S_WAIT;
                end
                S_DONE: begin
                    busy_out <= 1'b0;
                    done_out <= 1'b1;
                    state_q  <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

`ifdef UART_LOADER_CHECKSUM_EN
    always_ff @(posedge clock_in) begin
        if (reset_in)
            checksum_out <= '0;
        else if (state_q == S_IDLE && start_in)
            checksum_out <= '0;
        else if (state_q == S_EVAL && rx_valid_q)
            checksum_out <= checksum_out ^ rx_byte_q;
    end
`endif

endmodule

// File: tb/tb_uart_stream_loader.sv
// Bench for uart_stream_loader: two instances (16-bit MSB-first polled, 32-bit LSB-first IRQ with
// 4-word memory) share a reactive Avalon slave; written words are compared with a byte-list model.
`timescale 1ns/1ps
module tb_uart_stream_loader;

    localparam int AW_A = 11;
    localparam int IW_A = 16;
    localparam int AW_B = 2;
    localparam int IW_B = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst, start_a, start_b, waitrequest, irq;
    logic [AW_A:0]   length_a;
    logic [AW_B:0]   length_b;
    logic [31:0]     readdata;

    logic            a_cs, a_addr, a_rn, a_wn, a_mwr, a_busy, a_done;
    logic [AW_A-1:0] a_maddr;
    logic [IW_A-1:0] a_mdata;
    logic            b_cs, b_addr, b_rn, b_wn, b_mwr, b_busy, b_done;
    logic [AW_B-1:0] b_maddr;
    logic [IW_B-1:0] b_mdata;

    // Selects which instance the slave and monitors observe.
    logic            sel;
    logic            obs_cs, obs_addr, obs_rn, obs_wn, obs_mwr, obs_busy, obs_done;
    logic [31:0]     obs_maddr, obs_mdata;

    assign obs_cs    = sel ? b_cs   : a_cs;
    assign obs_addr  = sel ? b_addr : a_addr;
    assign obs_rn    = sel ? b_rn   : a_rn;
    assign obs_wn    = sel ? b_wn   : a_wn;
    assign obs_mwr   = sel ? b_mwr  : a_mwr;
    assign obs_busy  = sel ? b_busy : a_busy;
    assign obs_done  = sel ? b_done : a_done;
    assign obs_maddr = sel ? 32'(b_maddr) : 32'(a_maddr);
    assign obs_mdata = sel ? 32'(b_mdata) : 32'(a_mdata);

`ifdef UART_LOADER_CHECKSUM_EN
    logic [7:0] a_csum, b_csum, obs_csum;
    assign obs_csum = sel ? b_csum : a_csum;
`endif

    uart_stream_loader #(.ADDRESS_WIDTH(AW_A), .INSTR_WIDTH(IW_A), .MSB_FIRST(1'b1), .USE_IRQ(1'b0)) u_dut_a (
        .clock_in(clk), .reset_in(rst), .start_in(start_a), .length_in(length_a),
        .readdata_in(readdata), .waitrequest_in(waitrequest), .irq_in(irq),
        .chipselect_out(a_cs), .address_out(a_addr), .read_n_out(a_rn), .write_n_out(a_wn),
        .memory_wr_out(a_mwr), .memory_address_out(a_maddr), .memory_data_out(a_mdata),
        .busy_out(a_busy),
`ifdef UART_LOADER_CHECKSUM_EN
        .checksum_out(a_csum),
`endif
        .done_out(a_done)
    );

    uart_stream_loader #(.ADDRESS_WIDTH(AW_B), .INSTR_WIDTH(IW_B), .MSB_FIRST(1'b0), .USE_IRQ(1'b1)) u_dut_b (
        .clock_in(clk), .reset_in(rst), .start_in(start_b), .length_in(length_b),
        .readdata_in(readdata), .waitrequest_in(waitrequest), .irq_in(irq),
        .chipselect_out(b_cs), .address_out(b_addr), .read_n_out(b_rn), .write_n_out(b_wn),
        .memory_wr_out(b_mwr), .memory_address_out(b_maddr), .memory_data_out(b_mdata),
        .busy_out(b_busy),
`ifdef UART_LOADER_CHECKSUM_EN
        .checksum_out(b_csum),
`endif
        .done_out(b_done)
    );

    int          n_checks = 0;
    int          n_fail   = 0;

    logic [7:0]  stim_q[$];
    logic [7:0]  byte_q[$];
    logic [63:0] wr_q[$];
    logic [63:0] exp_q[$];
    int          rd_len_q[$];
    logic [7:0]  exp_csum;
    string       cur_tag;
    int          wait_cfg;
    bit          inval_alt;
    bit          give_invalid;
    int          run_len;
    bit          prev_mwr;
    logic [7:0]  slave_byte;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Avalon slave model plus write monitor, evaluated on every falling edge.
    initial begin
        waitrequest  = 1'b0;
        readdata     = '0;
        run_len      = 0;
        give_invalid = 1'b0;
        prev_mwr     = 1'b0;
        forever begin
            @(negedge clk);
            if (obs_mwr === 1'b1) begin
                wr_q.push_back({obs_maddr, obs_mdata});
                check("wr_single_cycle", 64'(prev_mwr), 64'(0));
                check("wr_not_during_read", 64'(obs_rn), 64'(1));
            end
            prev_mwr = obs_mwr;
            if (obs_rn === 1'b0) begin
                run_len++;
                if (run_len == 1) begin
                    check("cs_with_read", 64'(obs_cs), 64'(1));
                    check("reg_select", 64'(obs_addr), 64'(0));
                end
                if (run_len <= wait_cfg) begin
                    waitrequest = 1'b1;
                end else begin
                    waitrequest = 1'b0;
                    if ((inval_alt && give_invalid) || byte_q.size() == 0) begin
                        readdata     = $urandom & 32'hFFFF_7FFF;
                        give_invalid = 1'b0;
                    end else begin
                        slave_byte   = byte_q.pop_front();
                        readdata     = ($urandom & 32'hFFFF_7F00) | 32'h0000_8000 | {24'h0, slave_byte};
                        give_invalid = inval_alt;
                    end
                end
            end else begin
                if (run_len > 0) rd_len_q.push_back(run_len);
                run_len     = 0;
                waitrequest = 1'($urandom_range(0, 1));
                readdata    = $urandom;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check_reset(input string tag);
        check({tag, "_cs"},    64'(obs_cs),    64'(0));
        check({tag, "_rn"},    64'(obs_rn),    64'(1));
        check({tag, "_wn"},    64'(obs_wn),    64'(1));
        check({tag, "_addr"},  64'(obs_addr),  64'(0));
        check({tag, "_mwr"},   64'(obs_mwr),   64'(0));
        check({tag, "_maddr"}, 64'(obs_maddr), 64'(0));
        check({tag, "_mdata"}, 64'(obs_mdata), 64'(0));
        check({tag, "_busy"},  64'(obs_busy),  64'(0));
        check({tag, "_done"},  64'(obs_done),  64'(0));
`ifdef UART_LOADER_CHECKSUM_EN
        check({tag, "_csum"},  64'(obs_csum),  64'(0));
`endif
    endtask

    // Builds the expected write list from the byte stream, then pulses start for one cycle.
    task automatic start_load(input bit which, input int len, input int wcfg, input bit alt, input string tag);
        int          aw, nb, cap, words;
        bit          msb;
        logic [7:0]  src[$];
        logic [31:0] w;
        logic [7:0]  b;
        aw    = which ? AW_B : AW_A;
        nb    = which ? IW_B / 8 : IW_A / 8;
        msb   = which ? 1'b0 : 1'b1;
        cap   = 1 << aw;
        words = (len > cap) ? cap : len;
        while (stim_q.size() < words * nb) stim_q.push_back(8'($urandom));
        src = stim_q;
        stim_q.delete();
        exp_q.delete();
        exp_csum = 8'h00;
        for (int i = 0; i < words; i++) begin
            w = 32'h0;
            for (int j = 0; j < nb; j++) begin
                b = src[i * nb + j];
                exp_csum = exp_csum ^ b;
                w = w | (32'(b) << (8 * (msb ? (nb - 1 - j) : j)));
            end
            exp_q.push_back({32'(i % cap), w});
        end
        @(negedge clk);
        cur_tag      = tag;
        sel          = which;
        wait_cfg     = wcfg;
        inval_alt    = alt;
        give_invalid = 1'b0;
        byte_q       = src;
        wr_q.delete();
        rd_len_q.delete();
        if (which) begin
            start_b  = 1'b1;
            length_b = (AW_B + 1)'(len);
        end else begin
            start_a  = 1'b1;
            length_a = (AW_A + 1)'(len);
        end
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
        check({tag, "_busy_on_start"}, 64'(obs_busy), 64'(1));
        check({tag, "_done_cleared"},  64'(obs_done), 64'(0));
    endtask

    task automatic finish_load(output int done_lat);
        int guard;
        guard = 0;
        while (obs_done !== 1'b1 && guard < 4000) begin
            @(negedge clk);
            guard++;
        end
        done_lat = guard;
        check({cur_tag, "_done"},       64'(obs_done), 64'(1));
        check({cur_tag, "_busy_clear"}, 64'(obs_busy), 64'(0));
        repeat (2) @(negedge clk);
        check({cur_tag, "_done_sticky"}, 64'(obs_done), 64'(1));
        check({cur_tag, "_wr_count"}, 64'(wr_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++)
            check({cur_tag, "_wr_addr_data"}, wr_q[i], exp_q[i]);
        foreach (rd_len_q[i])
            check({cur_tag, "_read_len"}, 64'(rd_len_q[i]), 64'(wait_cfg + 1));
`ifdef UART_LOADER_CHECKSUM_EN
        check({cur_tag, "_checksum"}, 64'(obs_csum), 64'(exp_csum));
`endif
    endtask

    initial begin
        int lat, guard, cs_hits;
        rst       = 1'b1;
        start_a   = 1'b0;
        start_b   = 1'b0;
        length_a  = '0;
        length_b  = '0;
        irq       = 1'b1;
        sel       = 1'b0;
        wait_cfg  = 0;
        inval_alt = 1'b0;
        repeat (3) @(negedge clk);
        sel = 1'b0;
        check_reset("reset_a");
        sel = 1'b1;
        #1;
        check_reset("reset_b");
        @(negedge clk);
        rst = 1'b0;

        // Polled 16-bit MSB-first load of two words.
        stim_q = '{8'h12, 8'h34, 8'h56, 8'h78};
        start_load(1'b0, 2, 0, 1'b0, "t1");
        finish_load(lat);
        check("t1_word0", wr_q[0], {32'd0, 32'h1234});
        check("t1_word1", wr_q[1], {32'd1, 32'h5678});

        // Same bytes through slow reads with every other read carrying no data.
        stim_q = '{8'h12, 8'h34, 8'h56, 8'h78};
        start_load(1'b0, 2, 3, 1'b1, "t3");
        finish_load(lat);
        check("t3_word0", wr_q[0], {32'd0, 32'h1234});
        check("t3_word1", wr_q[1], {32'd1, 32'h5678});
        check("t3_read_count", 64'(rd_len_q.size()), 64'(7));

        // 32-bit LSB-first word.
        stim_q = '{8'h11, 8'h22, 8'h33, 8'h44};
        start_load(1'b1, 1, 0, 1'b0, "t2");
        finish_load(lat);
        check("t2_word0", wr_q[0], {32'd0, 32'h4433_2211});

        // IRQ gating: no bus activity while irq_in is low.
        irq = 1'b0;
        start_load(1'b1, 1, 1, 1'b0, "t4");
        cs_hits = 0;
        repeat (20) begin
            @(negedge clk);
            if (obs_cs !== 1'b0) cs_hits++;
        end
        check("t4_no_read_without_irq", 64'(cs_hits), 64'(0));
        check("t4_busy_waiting", 64'(obs_busy), 64'(1));
        irq = 1'b1;
        @(negedge clk);
        check("t4_read_after_irq", 64'(obs_cs), 64'(1));
        finish_load(lat);

        // Zero-length load.
        start_load(1'b0, 0, 0, 1'b0, "t5");
        finish_load(lat);
        check("t5_done_latency", 64'(lat), 64'(1));

        // Full 4-word memory, then an over-length request that must clamp.
        start_load(1'b1, 4, 0, 1'b0, "t6");
        finish_load(lat);
        check("t6_last_addr", 64'(wr_q[3][63:32]), 64'(3));
        start_load(1'b1, 7, 0, 1'b0, "t6_clamp");
        finish_load(lat);

        // Randomised loads on both configurations.
        for (int k = 0; k < 6; k++) begin
            bit which;
            int ln;
            which = 1'($urandom_range(0, 1));
            ln    = $urandom_range(1, 5);
            start_load(which, ln, $urandom_range(0, 2), 1'($urandom_range(0, 1)), "rnd");
            finish_load(lat);
        end

        // Reset in the middle of a word, then a clean load.
        stim_q = '{8'h99};
        start_load(1'b0, 1, 3, 1'b0, "t8a");
        void'(byte_q.pop_back());
        guard = 0;
        while (byte_q.size() != 0 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        repeat (3) @(negedge clk);
        guard = 0;
        while (obs_rn !== 1'b0 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("t8_mid_read", 64'(obs_rn), 64'(0));
        check("t8_no_write_yet", 64'(wr_q.size()), 64'(0));
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_reset("t8_reset");
        @(negedge clk);
        rst = 1'b0;
        stim_q = '{8'hAB, 8'hCD};
        start_load(1'b0, 1, 0, 1'b0, "t8b");
        finish_load(lat);
        check("t8b_word0", wr_q[0], {32'd0, 32'hABCD});
`ifdef UART_LOADER_CHECKSUM_EN
        check("t8b_checksum", 64'(obs_csum), 64'h66);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
